// File: rtl/sh7604_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// sh7604_pwr_ctrl
//   Power-down controller for the SH7604 core. Holds SBYCR (byte FFFFFE91)
//   and MSTPCR (word FFFFFE92) on the internal bus. It sequences sleep and
//   standby entry, external bus drain, standby, and an oscillator-settle
//   delay before the CPU clock restarts. It also drives the per-module stop
//   lines to the on-chip peripherals.
//
// Optional feature (compile-time macro SH7604_PWR_IRQ_WAKE_EN):
//   When it is defined, an unmasked IRQ_PEND in STANDBY starts the settle
//   sequence in the same way NMI does. When it is undefined, only NMI leaves
//   STANDBY.
//
// Parameters
//   NUM_MOD     number of module-stop bits (1..16)
//   SETTLE_W    settle counter width
//   SETTLE_CYC  CE_R cycles spent in SETTLE before RUN (1..2**SETTLE_W-1)
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   CE_R, CE_F        rising / falling clock enables
//   EN                global enable (gates FSM and register writes)
//   IBUS_*            internal bus slave (A, DI, DO, BA, WE, REQ, BUSY, ACT)
//   SLP_REQ           SLEEP instruction executed (1-cycle pulse)
//   IRQ_PEND, NMI     wake sources
//   BUS_IDLE          external bus / DMAC idle
//   SLEEP, SBY        CPU clock halted / chip in standby or settle
//   HIZ_OUT           pins tri-stated while in STANDBY with SBYCR.HIZ set
//   MSTP[NUM_MOD-1:0] effective module stops
//   WAKE              1-cycle pulse on return to RUN
// ---------------------------------------------------------------------------
module sh7604_pwr_ctrl #(
  parameter int NUM_MOD    = 5,
  parameter int SETTLE_W   = 12,
  parameter int SETTLE_CYC = 4095
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE_R,
  input  logic               CE_F,
  input  logic               EN,
  input  logic [31:0]        IBUS_A,
  input  logic [31:0]        IBUS_DI,
  output logic [31:0]        IBUS_DO,
  input  logic [3:0]         IBUS_BA,
  input  logic               IBUS_WE,
  input  logic               IBUS_REQ,
  output logic               IBUS_BUSY,
  output logic               IBUS_ACT,
  input  logic               SLP_REQ,
  input  logic               IRQ_PEND,
  input  logic               NMI,
  input  logic               BUS_IDLE,
  output logic               SLEEP,
  output logic               SBY,
  output logic               HIZ_OUT,
  output logic [NUM_MOD-1:0] MSTP,
  output logic               WAKE
);

  // SBYCR and MSTPCR share the aligned word at FFFFFE90.
  localparam logic [29:0]         REG_WADDR  = 30'h3FFF_FFA4;
  localparam logic [SETTLE_W-1:0] SETTLE_INI = SETTLE_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SLEEP,
    ST_DRAIN,
    ST_STANDBY,
    ST_SETTLE
  } state_t;

  state_t               state;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 sleep_r;
  logic                 stby_r;
  logic                 wake_r;

  logic                 sbycr_sby;
  logic                 sbycr_hiz;
  logic [NUM_MOD-1:0]   mstpcr;
  logic [31:0]          reg_do;

  logic                 hit;
  logic                 adv;
  logic                 wr_ok;
  logic                 standby_wake;
  logic [15:0]          mstpcr_ext;
  logic [7:0]           sbycr_rd;
  logic [15:0]          mstp_nxt;

  assign hit = (IBUS_A[31:2] == REG_WADDR);
  assign adv = EN && CE_R;

  // The register file is frozen while the CPU is in standby or settling.
  assign wr_ok = adv && IBUS_REQ && IBUS_WE && hit &&
                 (state != ST_STANDBY) && (state != ST_SETTLE);

`ifdef SH7604_PWR_IRQ_WAKE_EN
  assign standby_wake = NMI || IRQ_PEND;
`else
  assign standby_wake = NMI;
`endif

  assign mstpcr_ext = 16'(mstpcr);
  // Legacy SBYCR.MSTP[4:0] is a view of MSTPCR[4:0]; bit 5 always reads 0.
  assign sbycr_rd   = {sbycr_sby, sbycr_hiz, 1'b0, mstpcr_ext[4:0]};

  // Merge the lane writes into one next value for MSTPCR. When the SBYCR
  // lane and the MSTPCR low lane are written together, the MSTPCR lane
  // wins on the aliased bits.
  always_comb begin
    mstp_nxt = mstpcr_ext;
    if (wr_ok && IBUS_BA[2]) mstp_nxt[4:0]  = IBUS_DI[20:16];
    if (wr_ok && IBUS_BA[1]) mstp_nxt[15:8] = IBUS_DI[15:8];
    if (wr_ok && IBUS_BA[0]) mstp_nxt[7:0]  = IBUS_DI[7:0];
  end

  // Register writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sbycr_sby <= 1'b0;
      sbycr_hiz <= 1'b0;
      mstpcr    <= '0;
    end else if (wr_ok) begin
      if (IBUS_BA[2]) begin
        sbycr_sby <= IBUS_DI[23];
        sbycr_hiz <= IBUS_DI[22];
      end
      mstpcr <= mstp_nxt[NUM_MOD-1:0];
    end
  end

  // Read capture on the falling-phase enable
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reg_do <= '0;
    end else if (CE_F && IBUS_REQ && !IBUS_WE && hit) begin
      reg_do <= {sbycr_rd, 8'h00, mstpcr_ext};
    end
  end

  // Power-state FSM: the SBY bit is sampled before any same-cycle write
  // because it comes straight from the register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_RUN;
      settle_cnt <= '0;
      sleep_r    <= 1'b0;
      stby_r     <= 1'b0;
      wake_r     <= 1'b0;
    end else begin
      wake_r <= 1'b0;
      if (adv) begin
        case (state)
          ST_RUN: begin
            if (SLP_REQ) begin
              state   <= sbycr_sby ? ST_DRAIN : ST_SLEEP;
              sleep_r <= 1'b1;
            end
          end
          ST_SLEEP: begin
            if (IRQ_PEND || NMI) begin
              state   <= ST_RUN;
              sleep_r <= 1'b0;
              wake_r  <= 1'b1;
            end
          end
          ST_DRAIN: begin
            // NMI aborts standby entry even if the bus drained this cycle.
            if (NMI) begin
              state   <= ST_RUN;
              sleep_r <= 1'b0;
              wake_r  <= 1'b1;
            end else if (BUS_IDLE) begin
              state  <= ST_STANDBY;
              stby_r <= 1'b1;
            end
          end
          ST_STANDBY: begin
            if (standby_wake) begin
              state      <= ST_SETTLE;
              settle_cnt <= SETTLE_INI;
            end
          end
          ST_SETTLE: begin
            // Wake sources are ignored; only the oscillator delay matters.
            if (settle_cnt == '0) begin
              state   <= ST_RUN;
              sleep_r <= 1'b0;
              stby_r  <= 1'b0;
              wake_r  <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          default: begin
            state   <= ST_RUN;
            sleep_r <= 1'b0;
            stby_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SLEEP     = sleep_r;
  assign SBY       = stby_r;
  assign WAKE      = wake_r;
  assign HIZ_OUT   = sbycr_hiz && (state == ST_STANDBY);
  assign MSTP      = mstpcr | {NUM_MOD{stby_r}};
  assign IBUS_DO   = hit ? reg_do : 32'h0;
  assign IBUS_ACT  = hit;
  assign IBUS_BUSY = 1'b0;

  // Byte-offset bits, the unused top byte lane and SBYCR bit 5 carry no state.
  logic unused_ok;
  assign unused_ok = ^{IBUS_A[1:0], IBUS_DI[31:24], IBUS_DI[21], IBUS_BA[3],
                       mstp_nxt};

endmodule

// File: tb/tb_sh7604_pwr_ctrl.sv
module tb_sh7604_pwr_ctrl;

  localparam int NUM_MOD    = 5;
  localparam int SETTLE_W   = 12;
  localparam int SETTLE_CYC = 5;

  localparam logic [31:0] A_SBYCR  = 32'hFFFF_FE91;
  localparam logic [31:0] A_MSTPCR = 32'hFFFF_FE92;

  logic               CLK = 1'b0;
  logic               RST;
  logic               CE_R, CE_F, EN;
  logic [31:0]        IBUS_A, IBUS_DI, IBUS_DO;
  logic [3:0]         IBUS_BA;
  logic               IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
  logic               SLP_REQ, IRQ_PEND, NMI, BUS_IDLE;
  logic               SLEEP, SBY, HIZ_OUT, WAKE;
  logic [NUM_MOD-1:0] MSTP;

  int checks = 0;
  int errors = 0;

  sh7604_pwr_ctrl #(
    .NUM_MOD(NUM_MOD), .SETTLE_W(SETTLE_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .EN(EN),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY),
    .IBUS_ACT(IBUS_ACT), .SLP_REQ(SLP_REQ), .IRQ_PEND(IRQ_PEND), .NMI(NMI),
    .BUS_IDLE(BUS_IDLE), .SLEEP(SLEEP), .SBY(SBY), .HIZ_OUT(HIZ_OUT),
    .MSTP(MSTP), .WAKE(WAKE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
    IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_REQ = 1'b1; IBUS_WE = 1'b1;
    tick();
    IBUS_A = '0; IBUS_DI = '0; IBUS_BA = '0; IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic act);
    IBUS_A = a; IBUS_BA = 4'b1111; IBUS_REQ = 1'b1; IBUS_WE = 1'b0;
    tick();
    d = IBUS_DO;
    act = IBUS_ACT;
    IBUS_A = '0; IBUS_BA = '0; IBUS_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE_R = 1'b1; CE_F = 1'b1; EN = 1'b1;
    IBUS_A = '0; IBUS_DI = '0; IBUS_BA = '0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
    SLP_REQ = 1'b0; IRQ_PEND = 1'b0; NMI = 1'b0; BUS_IDLE = 1'b0;
    tick(); tick();
    checks++;
    if ({SLEEP, SBY, HIZ_OUT, WAKE, IBUS_BUSY, IBUS_ACT} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 000000", {SLEEP, SBY, HIZ_OUT, WAKE, IBUS_BUSY, IBUS_ACT});
    end
    checks++;
    if (MSTP !== 5'b0 || IBUS_DO !== 32'h0) begin
      errors++; $display("FAIL reset_data got MSTP=%b DO=%h want 0/0", MSTP, IBUS_DO);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    logic [31:0] d; logic act;
    EN = 1'b0;
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    checks++;
    if (SLEEP !== 1'b0) begin errors++; $display("FAIL en_off_sleep got %b want 0", SLEEP); end
    bus_wr(A_SBYCR, 32'h0080_0000, 4'b0100);
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL en_off_write got %h want 00000000", d); end
    EN = 1'b1; CE_R = 1'b0;
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    checks++;
    if (SLEEP !== 1'b0) begin errors++; $display("FAIL cer_off_sleep got %b want 0", SLEEP); end
    CE_R = 1'b1;
  endtask

  task automatic test_sbycr_rw();
    logic [31:0] d; logic act;
    bus_wr(A_SBYCR, 32'h00FF_0000, 4'b0100);
    checks++;
    if (MSTP !== 5'h1F) begin errors++; $display("FAIL sbycr_alias_mstp got %b want 11111", MSTP); end
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'hDF00_001F || act !== 1'b1) begin
      errors++; $display("FAIL sbycr_rd_ff got %h act=%b want DF00001F act=1", d, act);
    end
    bus_wr(A_SBYCR, 32'h0000_0000, 4'b0000);
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'hDF00_001F) begin errors++; $display("FAIL sbycr_no_lane got %h want DF00001F", d); end
    bus_wr(A_SBYCR, 32'h0080_0000, 4'b0100);
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'h8000_0000) begin errors++; $display("FAIL sbycr_rd_80 got %h want 80000000", d); end
    bus_rd(32'hFFFF_FE94, d, act);
    checks++;
    if (d !== 32'h0 || act !== 1'b0) begin
      errors++; $display("FAIL miss_addr got %h act=%b want 00000000 act=0", d, act);
    end
  endtask

  task automatic test_mstpcr();
    logic [31:0] d; logic act;
    bus_wr(A_MSTPCR, 32'h0000_FF05, 4'b0011);
    checks++;
    if (MSTP !== 5'b00101) begin errors++; $display("FAIL mstpcr_out got %b want 00101", MSTP); end
    bus_rd(A_MSTPCR, d, act);
    checks++;
    if (d !== 32'h8500_0005) begin errors++; $display("FAIL mstpcr_rd got %h want 85000005", d); end
    bus_wr(A_SBYCR, 32'h0000_0000, 4'b0100);
    checks++;
    if (MSTP !== 5'b00000) begin errors++; $display("FAIL mstp_alias_clr got %b want 00000", MSTP); end
  endtask

  task automatic test_sleep();
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    checks++;
    if ({SLEEP, SBY, WAKE} !== 3'b100) begin
      errors++; $display("FAIL sleep_enter got %b want 100", {SLEEP, SBY, WAKE});
    end
    tick(); tick();
    checks++;
    if (SLEEP !== 1'b1) begin errors++; $display("FAIL sleep_hold got %b want 1", SLEEP); end
    IRQ_PEND = 1'b1; tick(); IRQ_PEND = 1'b0;
    checks++;
    if ({SLEEP, WAKE} !== 2'b01) begin
      errors++; $display("FAIL sleep_wake got %b want 01", {SLEEP, WAKE});
    end
    tick();
    checks++;
    if (WAKE !== 1'b0) begin errors++; $display("FAIL wake_pulse got %b want 0", WAKE); end
  endtask

  task automatic test_standby();
    logic [31:0] d; logic act;
    bus_wr(A_SBYCR, 32'h00C0_0000, 4'b0100);
    BUS_IDLE = 1'b0;
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    tick(); tick();
    checks++;
    if ({SLEEP, SBY, HIZ_OUT} !== 3'b100) begin
      errors++; $display("FAIL drain_hold got %b want 100", {SLEEP, SBY, HIZ_OUT});
    end
    BUS_IDLE = 1'b1; tick(); BUS_IDLE = 1'b0;
    checks++;
    if ({SLEEP, SBY, HIZ_OUT} !== 3'b111 || MSTP !== 5'h1F) begin
      errors++; $display("FAIL standby_enter got %b MSTP=%b want 111 11111", {SLEEP, SBY, HIZ_OUT}, MSTP);
    end
    bus_wr(A_SBYCR, 32'h0000_0000, 4'b0100);
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'hC000_0000) begin errors++; $display("FAIL standby_wr_block got %h want C0000000", d); end
    NMI = 1'b1; tick(); NMI = 1'b0;
    checks++;
    if ({SLEEP, SBY, HIZ_OUT} !== 3'b110) begin
      errors++; $display("FAIL settle_enter got %b want 110", {SLEEP, SBY, HIZ_OUT});
    end
    for (int i = 0; i < SETTLE_CYC - 1; i++) tick();
    checks++;
    if ({SBY, WAKE} !== 2'b10) begin
      errors++; $display("FAIL settle_len got %b want 10", {SBY, WAKE});
    end
    tick();
    checks++;
    if ({SLEEP, SBY, WAKE} !== 3'b001 || MSTP !== 5'b0) begin
      errors++; $display("FAIL settle_exit got %b MSTP=%b want 001 00000", {SLEEP, SBY, WAKE}, MSTP);
    end
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'hC000_0000) begin errors++; $display("FAIL sbycr_kept got %h want C0000000", d); end
  endtask

  task automatic test_drain_abort();
    BUS_IDLE = 1'b0;
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    NMI = 1'b1; BUS_IDLE = 1'b1; tick(); NMI = 1'b0; BUS_IDLE = 1'b0;
    checks++;
    if ({SLEEP, SBY, WAKE} !== 3'b001) begin
      errors++; $display("FAIL drain_abort got %b want 001", {SLEEP, SBY, WAKE});
    end
    tick();
  endtask

  task automatic test_irq_standby();
    BUS_IDLE = 1'b1;
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    tick();
    BUS_IDLE = 1'b0;
    checks++;
    if ({SBY, HIZ_OUT} !== 2'b11) begin
      errors++; $display("FAIL irq_pre_standby got %b want 11", {SBY, HIZ_OUT});
    end
    IRQ_PEND = 1'b1; tick(); IRQ_PEND = 1'b0;
    checks++;
`ifdef SH7604_PWR_IRQ_WAKE_EN
    if ({SBY, HIZ_OUT} !== 2'b10) begin
      errors++; $display("FAIL irq_standby got %b want 10", {SBY, HIZ_OUT});
    end
`else
    if ({SBY, HIZ_OUT} !== 2'b11) begin
      errors++; $display("FAIL irq_standby got %b want 11", {SBY, HIZ_OUT});
    end
`endif
    NMI = 1'b1; tick(); NMI = 1'b0;
    for (int i = 0; i < SETTLE_CYC + 1; i++) tick();
    checks++;
    if ({SLEEP, SBY} !== 2'b00) begin
      errors++; $display("FAIL irq_standby_exit got %b want 00", {SLEEP, SBY});
    end
  endtask

  task automatic test_settle_reset();
    logic [31:0] d; logic act;
    BUS_IDLE = 1'b1;
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    tick();
    BUS_IDLE = 1'b0;
    NMI = 1'b1; tick(); NMI = 1'b0;
    tick(); tick();
    checks++;
    if ({SLEEP, SBY} !== 2'b11) begin
      errors++; $display("FAIL pre_rst_settle got %b want 11", {SLEEP, SBY});
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({SLEEP, SBY, HIZ_OUT, WAKE} !== 4'b0 || MSTP !== 5'b0) begin
      errors++; $display("FAIL async_rst got %b MSTP=%b want 0000 00000", {SLEEP, SBY, HIZ_OUT, WAKE}, MSTP);
    end
    tick();
    RST = 1'b0;
    bus_rd(A_SBYCR, d, act);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_sbycr got %h want 00000000", d); end
    SLP_REQ = 1'b1; tick(); SLP_REQ = 1'b0;
    checks++;
    if ({SLEEP, SBY} !== 2'b10) begin
      errors++; $display("FAIL rst_state_run got %b want 10", {SLEEP, SBY});
    end
    IRQ_PEND = 1'b1; tick(); IRQ_PEND = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_enable();
    test_sbycr_rw();
    test_mstpcr();
    test_sleep();
    test_standby();
    test_drain_abort();
    test_irq_standby();
    test_settle_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
